// File: rtl/delay_sweep_ctrl.sv
// rtl/delay_sweep_ctrl.sv - delay-calibration sweep sequencer driving R/G/B whole/rising/falling delay buses
module delay_sweep_ctrl #(
  parameter int DWELL_CYCLES = 200000,
  parameter int MAX_DELAY    = 10
) (
  input  logic       clk_x10,
  input  logic       g_rst,
  input  logic       start,
  input  logic       abort,
  input  logic       hold,
  input  logic [1:0] mode,
  input  logic [2:0] ch_sel,
  output logic [3:0] r_whole_delay_value,
  output logic [3:0] g_whole_delay_value,
  output logic [3:0] b_whole_delay_value,
  output logic [3:0] r_rising_delay_value,
  output logic [3:0] g_rising_delay_value,
  output logic [3:0] b_rising_delay_value,
  output logic [3:0] r_falling_delay_value,
  output logic [3:0] g_falling_delay_value,
  output logic [3:0] b_falling_delay_value,
  output logic [3:0] step_index,
  output logic       step_pulse,
  output logic       busy,
  output logic       done
);

  localparam logic [23:0] CNT_LOAD  = 24'(DWELL_CYCLES - 1);
  localparam logic [3:0]  LAST_STEP = 4'(MAX_DELAY);

  typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

  state_t      state;
  logic [1:0]  rst_pipe;
  logic        rst_n;
  logic        start_q;
  logic [1:0]  mode_q;
  logic [2:0]  ch_q;
  logic [1:0]  sweep_mode;
  logic [2:0]  sweep_ch;
  logic [23:0] cnt;
  logic [3:0]  next_step;
  // Field arrays are indexed by channel: 2 = r, 1 = g, 0 = b (matches ch_sel bit order).
  logic [3:0]  whole_q [0:2];
  logic [3:0]  rise_q  [0:2];
  logic [3:0]  fall_q  [0:2];

  assign rst_n     = rst_pipe[1];
  assign next_step = step_index + 4'd1;

  assign r_whole_delay_value   = whole_q[2];
  assign g_whole_delay_value   = whole_q[1];
  assign b_whole_delay_value   = whole_q[0];
  assign r_rising_delay_value  = rise_q[2];
  assign g_rising_delay_value  = rise_q[1];
  assign b_rising_delay_value  = rise_q[0];
  assign r_falling_delay_value = fall_q[2];
  assign g_falling_delay_value = fall_q[1];
  assign b_falling_delay_value = fall_q[0];

  // Reset asserts immediately, releases two clk_x10 edges after g_rst rises.
  always_ff @(posedge clk_x10 or negedge g_rst) begin
    if (!g_rst) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end

  // Register the request and its settings; a start seen with abort, or with no channel, is dropped here.
  always_ff @(posedge clk_x10 or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      mode_q  <= 2'd0;
      ch_q    <= 3'd0;
    end else begin
      start_q <= start & ~abort & (ch_sel != 3'b000);
      mode_q  <= mode;
      ch_q    <= ch_sel;
    end
  end

  // Sweep FSM with registered outputs; abort clears everything on the next edge.
  always_ff @(posedge clk_x10 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      step_index <= 4'd0;
      step_pulse <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cnt        <= 24'd0;
      sweep_mode <= 2'd0;
      sweep_ch   <= 3'd0;
      for (int c = 0; c < 3; c++) begin
        whole_q[c] <= 4'd0;
        rise_q[c]  <= 4'd0;
        fall_q[c]  <= 4'd0;
      end
    end else if (abort) begin
      state      <= IDLE;
      step_index <= 4'd0;
      step_pulse <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cnt        <= 24'd0;
      sweep_mode <= 2'd0;
      sweep_ch   <= 3'd0;
      for (int c = 0; c < 3; c++) begin
        whole_q[c] <= 4'd0;
        rise_q[c]  <= 4'd0;
        fall_q[c]  <= 4'd0;
      end
    end else begin
      step_pulse <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_q) begin
            state      <= DWELL;
            sweep_mode <= mode_q;
            sweep_ch   <= ch_q;
            step_index <= 4'd0;
            cnt        <= CNT_LOAD;
            step_pulse <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            // Step 0 is all zeros, and non-targeted fields must read 0 for the whole sweep.
            for (int c = 0; c < 3; c++) begin
              whole_q[c] <= 4'd0;
              rise_q[c]  <= 4'd0;
              fall_q[c]  <= 4'd0;
            end
          end
        end
        DWELL: begin
          if (!hold) begin
            if (cnt != 24'd0) begin
              cnt <= cnt - 24'd1;
            end else if (step_index < LAST_STEP) begin
              step_index <= next_step;
              cnt        <= CNT_LOAD;
              step_pulse <= 1'b1;
              // mode: 0 whole, 1 rising, 2 falling, 3 rising+falling.
              for (int c = 0; c < 3; c++) begin
                if (sweep_ch[c]) begin
                  if (sweep_mode == 2'd0) whole_q[c] <= next_step;
                  if (sweep_mode[0])      rise_q[c]  <= next_step;
                  if (sweep_mode[1])      fall_q[c]  <= next_step;
                end
              end
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
